// File: rtl/riscv_multicycle_control.sv
// ============================================================================
// Module   : riscv_multicycle_control
// Brief    : Control FSM for a multicycle RV32 datapath (R/I ALU, lw, sw, beq, jal)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic                   funct7b5,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic [3:0]             alu_ctl,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic                   iord,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_source,
    output logic                   reg_write,
    output logic [1:0]             mem_to_reg,
    output logic                   illegal,
    output logic                   retire,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic [3:0]             state_dbg
);

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   w_funct3_ok;
    logic [3:0]             w_alu_func;

    // Both R-type and I-type ALU ops share the same funct3 subset.
    assign w_funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                         (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        w_alu_func = c_ALU_ADD;
        case (funct3)
            3'b010:  w_alu_func = c_ALU_SLT;
            3'b110:  w_alu_func = c_ALU_OR;
            3'b111:  w_alu_func = c_ALU_AND;
            default: w_alu_func = c_ALU_ADD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_ctl    = c_ALU_ADD;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'd0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                case (opcode)
                    c_OP_LOAD, c_OP_STORE: state_d = MEMADR;
                    c_OP_REG:    state_d = w_funct3_ok ? EXEC_R : ILLEGAL;
                    c_OP_IMM:    state_d = w_funct3_ok ? EXEC_I : ILLEGAL;
                    c_OP_BRANCH: state_d = (funct3 == 3'b000) ? BRANCH : ILLEGAL;
                    c_OP_JAL:    state_d = JAL;
                    default:     state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                state_d   = (opcode == c_OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd0;
                alu_ctl   = (funct3 == 3'b000 && funct7b5) ? c_ALU_SUB : w_alu_func;
                state_d   = ALUWB;
            end
            EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_ctl   = w_alu_func;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd0;
                alu_ctl   = c_ALU_SUB;
                pc_source = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                pc_source  = 1'b1;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'd2;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset blocks every side effect, even mid memory access.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign retired_count = count_q;
    assign state_dbg     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_control.sv
// ============================================================================
// Module   : tb_riscv_multicycle_control
// Brief    : Directed self-checking bench for riscv_multicycle_control
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_multicycle_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  alu_ctl;
    logic [1:0]  alu_src_a, alu_src_b, mem_to_reg;
    logic        iord, mem_read, mem_write, ir_write, pc_write, pc_source;
    logic        reg_write, illegal, retire;
    logic [31:0] retired_count;
    logic [3:0]  state_dbg;

    riscv_multicycle_control #(.COUNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .alu_ctl(alu_ctl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .retire(retire), .retired_count(retired_count), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  st;
        logic [3:0]  alu;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        iord;
        logic        mr;
        logic        mw;
        logic        irw;
        logic        pcw;
        logic        pcs;
        logic        rw;
        logic [1:0]  m2r;
        logic        ill;
        logic        ret;
        logic [31:0] cnt;
    } exp_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt = '0;

    function automatic exp_t mk(input logic [3:0] st);
        exp_t e = '0;
        e.st  = st;
        e.alu = 4'b0010;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = mk(4'd0);
        e.mr = 1'b1; e.sb = 2'd1; e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction

    function automatic exp_t e_decode();
        exp_t e = mk(4'd1);
        e.sa = 2'd2; e.sb = 2'd2;
        return e;
    endfunction

    function automatic exp_t e_memadr();
        exp_t e = mk(4'd2);
        e.sa = 2'd1; e.sb = 2'd2;
        return e;
    endfunction

    function automatic exp_t e_memread();
        exp_t e = mk(4'd3);
        e.mr = 1'b1; e.iord = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memwb();
        exp_t e = mk(4'd4);
        e.rw = 1'b1; e.m2r = 2'd1; e.ret = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memwrite(input logic rdy);
        exp_t e = mk(4'd5);
        e.mw = 1'b1; e.iord = 1'b1; e.ret = rdy;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic is_imm, input logic [3:0] alu);
        exp_t e = mk(is_imm ? 4'd7 : 4'd6);
        e.sa = 2'd1; e.sb = is_imm ? 2'd2 : 2'd0; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t e_aluwb();
        exp_t e = mk(4'd8);
        e.rw = 1'b1; e.ret = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_branch(input logic z);
        exp_t e = mk(4'd9);
        e.sa = 2'd1; e.alu = 4'b0110; e.pcs = 1'b1; e.pcw = z; e.ret = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_jal();
        exp_t e = mk(4'd10);
        e.pcs = 1'b1; e.pcw = 1'b1; e.rw = 1'b1; e.m2r = 2'd2; e.ret = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_ill();
        exp_t e = mk(4'd11);
        e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t strip(input exp_t e_in);
        exp_t e = e_in;
        e.mr = 1'b0; e.mw = 1'b0; e.irw = 1'b0; e.pcw = 1'b0; e.rw = 1'b0; e.ret = 1'b0;
        return e;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare at the falling edge.
    task automatic step(input string tag, input logic rst, input logic [6:0] opc,
                        input logic [2:0] f3, input logic f7, input logic z,
                        input logic rdy, input exp_t e);
        exp_t want, got;
        reset = rst; opcode = opc; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(negedge clock);
        want = sb_q.pop_front();
        got = {state_dbg, alu_ctl, alu_src_a, alu_src_b, iord, mem_read, mem_write,
               ir_write, pc_write, pc_source, reg_write, mem_to_reg, illegal, retire,
               retired_count};
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
        if (rst) exp_cnt = '0;
        else if (want.ret) exp_cnt = exp_cnt + 32'd1;
        @(posedge clock);
        #1;
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input logic [3:0] alu);
        step({tag, "_fetch"},  1'b0, opc, f3, f7, 1'b0, 1'b1, e_fetch(1'b1));
        step({tag, "_decode"}, 1'b0, opc, f3, f7, 1'b0, 1'b0, e_decode());
        step({tag, "_exec"},   1'b0, opc, f3, f7, 1'b0, 1'b1, e_exec(opc == OP_I, alu));
        step({tag, "_wb"},     1'b0, opc, f3, f7, 1'b0, 1'b0, e_aluwb());
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        step("reset_hold", 1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, strip(e_fetch(1'b1)));
        step("fetch_stall", 1'b0, OP_R, 3'd0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

        alu_instr("add",  OP_R, 3'b000, 1'b0, 4'b0010);
        alu_instr("sub",  OP_R, 3'b000, 1'b1, 4'b0110);
        alu_instr("and",  OP_R, 3'b111, 1'b0, 4'b0000);
        alu_instr("or",   OP_R, 3'b110, 1'b0, 4'b0001);
        alu_instr("slt",  OP_R, 3'b010, 1'b0, 4'b0111);
        alu_instr("addi", OP_I, 3'b000, 1'b1, 4'b0010);
        alu_instr("ori",  OP_I, 3'b110, 1'b0, 4'b0001);

        step("lw_fetch",  1'b0, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        step("lw_decode", 1'b0, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, e_decode());
        step("lw_memadr", 1'b0, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, e_memadr());
        for (int i = 0; i < 3; i++)
            step("lw_wait", 1'b0, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, e_memread());
        step("lw_read",   1'b0, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, e_memread());
        step("lw_wb",     1'b0, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, e_memwb());

        step("sw_fetch",  1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        step("sw_decode", 1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_decode());
        step("sw_memadr", 1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_memadr());
        step("sw_write",  1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_memwrite(1'b1));

        for (int z = 1; z >= 0; z--) begin
            step("beq_fetch",  1'b0, OP_BEQ, 3'b000, 1'b0, z[0], 1'b1, e_fetch(1'b1));
            step("beq_decode", 1'b0, OP_BEQ, 3'b000, 1'b0, z[0], 1'b1, e_decode());
            step("beq_branch", 1'b0, OP_BEQ, 3'b000, 1'b0, z[0], 1'b1, e_branch(z[0]));
        end

        step("swr_fetch",  1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        step("swr_decode", 1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_decode());
        step("swr_memadr", 1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_memadr());
        step("swr_wait",   1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, e_memwrite(1'b0));
        step("swr_reset",  1'b1, OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, strip(e_memwrite(1'b0)));
        step("jal_fetch",  1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        step("jal_decode", 1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, e_decode());
        step("jal_exec",   1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, e_jal());

        step("badf3_fetch",  1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        step("badf3_decode", 1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, e_decode());
        step("badf3_ill",    1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, e_ill());
        step("badf3_reset",  1'b1, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, e_ill());
        step("badf3_after",  1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

        alu_instr("add2", OP_R, 3'b000, 1'b0, 4'b0010);
        step("badop_fetch",  1'b0, 7'h7f, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        step("badop_decode", 1'b0, 7'h7f, 3'b000, 1'b0, 1'b0, 1'b1, e_decode());
        for (int i = 0; i < 10; i++)
            step("badop_hold", 1'b0, 7'h7f, 3'b000, 1'b0, i[0], i[1], e_ill());
        step("badop_reset", 1'b1, 7'h7f, 3'b000, 1'b0, 1'b0, 1'b1, e_ill());
        step("badop_after", 1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

        step("beqf3_fetch",  1'b0, OP_BEQ, 3'b001, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("beqf3_decode", 1'b0, OP_BEQ, 3'b001, 1'b0, 1'b1, 1'b1, e_decode());
        step("beqf3_ill",    1'b0, OP_BEQ, 3'b001, 1'b0, 1'b1, 1'b1, e_ill());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_multicycle_control.md
Name: riscv_multicycle_control

Overview:
- Moore/Mealy control FSM for the multicycle RISC-V datapath.
- Sequences fetch, decode, execute, memory and writeback phases.
- Drives the ALU's 4-bit control code and operand selects, and consumes the ALU Zero flag for branches.
- Supports R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), lw, sw, beq and jal. Memory has a ready handshake. Also provides a retire pulse and an instruction counter.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter.

Ports:
clock  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
opcode  input  7  IR[6:0].
funct3  input  3  IR[14:12].
funct7b5  input  1  IR[30].
zero  input  1  ALU Zero flag (ALU result == 0).
mem_ready  input  1  memory completes current read/write this cycle.
alu_ctl  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
alu_src_a  output  2  0 PC, 1 regA, 2 oldPC.
alu_src_b  output  2  0 regB, 1 constant 4, 2 immediate.
iord  output  1  memory address: 0 PC, 1 ALUOut.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
ir_write  output  1  load IR and oldPC.
pc_write  output  1  load PC.
pc_source  output  1  PC input: 0 ALU result, 1 ALUOut.
reg_write  output  1  register-file write.
mem_to_reg  output  2  writeback: 0 ALUOut, 1 MDR, 2 PC.
illegal  output  1  high while in ILLEGAL.
retire  output  1  one-cycle pulse per completed instruction.
retired_count  output  COUNT_WIDTH  completed instructions.
state_dbg  output  4  current state encoding.

Behaviour:
Reset:
- reset=1 at an edge: state←FETCH, retired_count←0. Reset has priority over every transition, including mid-memory-access.
- While reset=1: mem_read, mem_write, ir_write, pc_write, reg_write, retire forced 0.
- Outputs after reset (FETCH, mem_ready=0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctl=0010, pc_source=0, mem_to_reg=0, all write strobes 0, illegal=0, state_dbg=0.

Defaults: every output not listed for a state is 0 (alu_ctl 0010).

States (encodings 0..11):
- FETCH: mem_read=1, iord=0, srcA=0, srcB=1, ADD.
  - mem_ready=0: stay, request held stable.
  - mem_ready=1: ir_write=1, pc_write=1, pc_source=0 same cycle; →DECODE.
- DECODE: srcA=2, srcB=2, ADD (branch/jump target into ALUOut).
  - Next state by opcode: 0000011/0100011→MEMADR; 0110011→EXEC_R; 0010011→EXEC_I; 1100011→BRANCH; 1101111→JAL.
  - Any other opcode, or an unsupported funct3 (R: not 000/010/110/111; I: not 000/010/110/111; beq: not 000) →ILLEGAL.
- MEMADR: srcA=1, srcB=2, ADD. lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: mem_read=1, iord=1. Wait for mem_ready; then →MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, retire; →FETCH.
- MEMWRITE: mem_write=1, iord=1. Wait for mem_ready; then retire; →FETCH.
- EXEC_R: srcA=1, srcB=0; →ALUWB.
  - alu_ctl: funct3 000 → ADD (funct7b5=0) / SUB (funct7b5=1); 010→SLT; 110→OR; 111→AND.
- EXEC_I: srcA=1, srcB=2; →ALUWB.
  - Same funct3 map as EXEC_R, but funct7b5 is ignored (000 always ADD).
- ALUWB: reg_write=1, mem_to_reg=0, retire; →FETCH.
- BRANCH: srcA=1, srcB=0, SUB, pc_source=1, pc_write=zero, retire; →FETCH.
- JAL: pc_source=1, pc_write=1, reg_write=1, mem_to_reg=2, retire; →FETCH.
- ILLEGAL: all strobes 0, illegal=1. Stays until reset; no retire.

Latency with mem_ready=1 throughout: R/I 4 cycles, lw 5, sw 4, beq/jal 3. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.

Inputs: opcode and funct fields are taken from the IR, stable from DECODE until the next FETCH completes. mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Counter: retired_count increments by 1 in the cycle after retire and wraps 2^COUNT_WIDTH−1→0.

Test Plan:
- Reset, then add (0110011/000/f7b5=0), mem_ready=1 → states FETCH, DECODE, EXEC_R (alu_ctl 0010), ALUWB (reg_write=1, retire=1); retired_count=1.
- funct map: R f7b5=1/000→0110; 111→0000; 110→0001; 010→0111; addi with f7b5=1→0010; R funct3 001→ILLEGAL.
- lw, mem_ready low for 3 cycles in MEMREAD → mem_read=1 and iord=1 held, no state change; completes in 8 cycles total with mem_to_reg=1.
- beq with zero=1 → BRANCH has pc_write=1, pc_source=1. With zero=0 → pc_write=0. Both retire; count +1 each.
- opcode 1111111 → ILLEGAL, illegal=1, all strobes 0 for 10 cycles, count frozen; reset → FETCH, illegal=0.
- Reset in MEMWRITE with mem_ready=0 → mem_write=0 during reset; next state FETCH, count 0; jal afterward gives pc_write=1, reg_write=1, mem_to_reg=2 in 3 cycles.
